// File: rtl/multicycle_ctrl.sv
// Multi-cycle instruction sequencer: fetch, decode, execute, memory and writeback.
// Owns the PC, the instruction register and the retired-instruction counter.
module multicycle_ctrl #(
  parameter int              PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            halt_i,
  output logic            imem_req_o,
  output logic [PC_W-1:0] imem_addr_o,
  input  logic            imem_ready_i,
  input  logic [31:0]     imem_rdata_i,
  output logic [31:0]     instr_o,
  input  logic            reg_write_en_i,
  input  logic            branch_i,
  input  logic            branch_taken_i,
  input  logic [PC_W-1:0] branch_target_i,
  output logic            alu_en_o,
  output logic            dmem_req_o,
  output logic            dmem_we_o,
  input  logic            dmem_ready_i,
  output logic            rf_we_o,
  output logic [PC_W-1:0] pc_o,
  output logic [2:0]      state_o,
  output logic            illegal_o,
  output logic [31:0]     retired_o
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4
  } state_e;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_B     = 7'b1100011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [31:0]     instr_q, instr_d;
  logic [31:0]     retired_q, retired_d;

  logic [6:0]      opcode;
  logic            is_alu, is_branch, is_load, is_store, is_legal;
  logic [PC_W-1:0] pc_plus4;

  assign opcode    = instr_q[6:0];
  assign is_alu    = (opcode == OP_R) || (opcode == OP_I);
  assign is_branch = (opcode == OP_B);
  assign is_load   = (opcode == OP_LOAD);
  assign is_store  = (opcode == OP_STORE);
  assign is_legal  = is_alu || is_branch || is_load || is_store;
  assign pc_plus4  = pc_q + PC_W'(4);

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    retired_d  = retired_q;
    imem_req_o = 1'b0;
    alu_en_o   = 1'b0;
    dmem_req_o = 1'b0;
    dmem_we_o  = 1'b0;
    rf_we_o    = 1'b0;
    illegal_o  = 1'b0;

    case (state_q)
      FETCH: begin
        imem_req_o = !halt_i;
        if (!halt_i && imem_ready_i) begin
          instr_d = imem_rdata_i;
          state_d = DECODE;
        end
      end
      DECODE: begin
        if (is_legal) begin
          state_d = EXEC;
        end else begin
          illegal_o = 1'b1;
          pc_d      = pc_plus4;
          retired_d = retired_q + 32'd1;
          state_d   = FETCH;
        end
      end
      EXEC: begin
        alu_en_o = 1'b1;
        if (is_alu) begin
          state_d = WB;
        end else if (is_branch) begin
          // The decoder flag qualifies the ALU condition before redirecting.
          pc_d      = (branch_i && branch_taken_i) ? branch_target_i : pc_plus4;
          retired_d = retired_q + 32'd1;
          state_d   = FETCH;
        end else begin
          state_d = MEM;
        end
      end
      MEM: begin
        dmem_req_o = 1'b1;
        dmem_we_o  = is_store;
        if (dmem_ready_i) begin
          if (is_store) begin
            pc_d      = pc_plus4;
            retired_d = retired_q + 32'd1;
            state_d   = FETCH;
          end else begin
            state_d = WB;
          end
        end
      end
      WB: begin
        rf_we_o   = reg_write_en_i;
        pc_d      = pc_plus4;
        retired_d = retired_q + 32'd1;
        state_d   = FETCH;
      end
      default: state_d = FETCH;
    endcase

    // Reset abandons any transaction in flight without letting a strobe escape.
    if (rst_i) begin
      imem_req_o = 1'b0;
      alu_en_o   = 1'b0;
      dmem_req_o = 1'b0;
      dmem_we_o  = 1'b0;
      rf_we_o    = 1'b0;
      illegal_o  = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= FETCH;
      pc_q      <= RESET_PC;
      instr_q   <= 32'd0;
      retired_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      retired_q <= retired_d;
    end
  end

  assign imem_addr_o = pc_q;
  assign pc_o        = pc_q;
  assign instr_o     = instr_q;
  assign state_o     = state_q;
  assign retired_o   = retired_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: directed scenarios plus randomized instructions
// checked against a per-instruction latency/effect model.
module tb_multicycle_ctrl;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        halt_i = 1'b0;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ready_i = 1'b0;
  logic [31:0] imem_rdata_i = 32'd0;
  logic [31:0] instr_o;
  logic        reg_write_en_i = 1'b0;
  logic        branch_i = 1'b0;
  logic        branch_taken_i = 1'b0;
  logic [31:0] branch_target_i = 32'd0;
  logic        alu_en_o;
  logic        dmem_req_o;
  logic        dmem_we_o;
  logic        dmem_ready_i = 1'b0;
  logic        rf_we_o;
  logic [31:0] pc_o;
  logic [2:0]  state_o;
  logic        illegal_o;
  logic [31:0] retired_o;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_pc;
  logic [31:0] m_ret;
  logic [31:0] m_instr;

  multicycle_ctrl #(.PC_W(32), .RESET_PC(RESET_PC)) dut (
    .clk_i(clk), .rst_i(rst_i), .halt_i(halt_i),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
    .imem_ready_i(imem_ready_i), .imem_rdata_i(imem_rdata_i),
    .instr_o(instr_o), .reg_write_en_i(reg_write_en_i),
    .branch_i(branch_i), .branch_taken_i(branch_taken_i),
    .branch_target_i(branch_target_i), .alu_en_o(alu_en_o),
    .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o),
    .dmem_ready_i(dmem_ready_i), .rf_we_o(rf_we_o), .pc_o(pc_o),
    .state_o(state_o), .illegal_o(illegal_o), .retired_o(retired_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [5:0] strobes();
    return {imem_req_o, alu_en_o, dmem_req_o, dmem_we_o, rf_we_o, illegal_o};
  endfunction

  // Runs one instruction for exactly the cycle count the model predicts, then
  // checks architectural state and how many cycles each strobe was seen.
  task automatic do_instr(input logic [31:0] ins, input int iw, input int dw,
                          input bit tk, input logic [31:0] tgt, input bit rwe);
    int cls; // 0 R/I, 1 branch, 2 load, 3 store, 4 illegal
    int n, n_freq, n_bad, n_alu, n_ill, n_dreq, n_dwe, n_rf;
    bit mem;
    logic [31:0] start_pc, exp_pc;
    case (ins[6:0])
      7'b0110011, 7'b0010011: cls = 0;
      7'b1100011:             cls = 1;
      7'b0000011:             cls = 2;
      7'b0100011:             cls = 3;
      default:                cls = 4;
    endcase
    mem = (cls == 2) || (cls == 3);
    case (cls)
      0: n = 4; 1: n = 3; 2: n = 5; 3: n = 4; default: n = 2;
    endcase
    n = n + iw + (mem ? dw : 0);
    start_pc = m_pc;
    exp_pc = (cls == 1 && tk) ? tgt : m_pc + 32'd4;
    n_freq = 0; n_bad = 0; n_alu = 0; n_ill = 0; n_dreq = 0; n_dwe = 0; n_rf = 0;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      halt_i          = 1'b0;
      imem_ready_i    = (c < iw) ? 1'b0 : ((c == iw) ? 1'b1 : 1'($urandom_range(0, 1)));
      imem_rdata_i    = (c == iw) ? ins : $urandom;
      if (mem && c >= iw + 3) dmem_ready_i = (c >= iw + 3 + dw);
      else                    dmem_ready_i = 1'($urandom_range(0, 1));
      reg_write_en_i  = rwe;
      branch_i        = (cls == 1);
      branch_taken_i  = tk;
      branch_target_i = tgt;
      #1;
      if (imem_req_o) n_freq++;
      if (c <= iw && (!imem_req_o || imem_addr_o !== start_pc)) n_bad++;
      if (alu_en_o)   n_alu++;
      if (illegal_o)  n_ill++;
      if (dmem_req_o) n_dreq++;
      if (dmem_we_o)  n_dwe++;
      if (rf_we_o)    n_rf++;
    end
    @(negedge clk);
    imem_ready_i = 1'b0;
    dmem_ready_i = 1'b0;
    #1;
    m_pc = exp_pc;
    m_ret = m_ret + 32'd1;
    m_instr = ins;
    check("end_state",   32'(state_o), 32'd0);
    check("pc",          pc_o, m_pc);
    check("retired",     retired_o, m_ret);
    check("instr",       instr_o, m_instr);
    check("fetch_req",   32'(n_freq), 32'(iw + 1));
    check("fetch_addr",  32'(n_bad), 32'd0);
    check("alu_en",      32'(n_alu), (cls == 4) ? 32'd0 : 32'd1);
    check("illegal",     32'(n_ill), (cls == 4) ? 32'd1 : 32'd0);
    check("dmem_req",    32'(n_dreq), mem ? 32'(dw + 1) : 32'd0);
    check("dmem_we",     32'(n_dwe), (cls == 3) ? 32'(dw + 1) : 32'd0);
    check("rf_we",       32'(n_rf), ((cls == 0 || cls == 2) && rwe) ? 32'd1 : 32'd0);
  endtask

  initial begin
    logic [6:0]  ops [5];
    logic [31:0] ins;
    logic [6:0]  op;
    ops[0] = 7'b0110011; ops[1] = 7'b0010011; ops[2] = 7'b1100011;
    ops[3] = 7'b0000011; ops[4] = 7'b0100011;

    // Reset: strobes suppressed even though FETCH with halt low would request.
    imem_ready_i = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    check("rst_state",   32'(state_o), 32'd0);
    check("rst_pc",      pc_o, RESET_PC);
    check("rst_instr",   instr_o, 32'd0);
    check("rst_retired", retired_o, 32'd0);
    check("rst_strobes", 32'(strobes()), 32'd0);
    rst_i = 1'b0;
    imem_ready_i = 1'b0;
    m_pc = RESET_PC; m_ret = 32'd0; m_instr = 32'd0;

    do_instr(32'h002081B3, 0, 0, 1'b0, 32'd0, 1'b1);   // ADD
    do_instr(32'h0000A103, 0, 3, 1'b0, 32'd0, 1'b1);   // LW with 3 wait cycles
    do_instr(32'h0020A023, 0, 0, 1'b0, 32'd0, 1'b0);   // SW
    do_instr(32'h00000063, 0, 0, 1'b1, 32'h100, 1'b0); // BEQ taken
    do_instr(32'h00000063, 0, 0, 1'b0, 32'h200, 1'b0); // BEQ not taken
    do_instr(32'h0000007F, 0, 0, 1'b0, 32'd0, 1'b0);   // illegal opcode

    // Halt: no request, ready ignored, nothing moves.
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      halt_i = 1'b1;
      imem_ready_i = 1'b1;
      imem_rdata_i = $urandom;
      #1;
      check("halt_req",   32'(imem_req_o), 32'd0);
      check("halt_state", 32'(state_o), 32'd0);
    end
    @(negedge clk);
    halt_i = 1'b0;
    imem_ready_i = 1'b0;
    #1;
    check("halt_pc",    pc_o, m_pc);
    check("halt_instr", instr_o, m_instr);

    // Reset while a load waits in MEM.
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      imem_ready_i = 1'b1;
      imem_rdata_i = 32'h0000A103;
      dmem_ready_i = 1'b0;
      #1;
      if (c == 3) check("mem_before_rst", 32'(dmem_req_o), 32'd1);
    end
    @(negedge clk);
    rst_i = 1'b1;
    imem_ready_i = 1'b0;
    #1;
    check("rst_mid_strobes", 32'(strobes()), 32'd0);
    @(negedge clk);
    #1;
    check("rst_mid_state",   32'(state_o), 32'd0);
    check("rst_mid_pc",      pc_o, RESET_PC);
    check("rst_mid_retired", retired_o, 32'd0);
    check("rst_mid_strobes2", 32'(strobes()), 32'd0);
    rst_i = 1'b0;
    m_pc = RESET_PC; m_ret = 32'd0; m_instr = 32'd0;
    do_instr(32'h002081B3, 1, 0, 1'b0, 32'd0, 1'b1);

    // PC wrap at the top of the address space.
    do_instr(32'h00000063, 0, 0, 1'b1, 32'hFFFF_FFFC, 1'b0);
    do_instr(32'h00100093, 0, 0, 1'b0, 32'd0, 1'b1);   // ADDI

    // Randomized instruction stream.
    for (int k = 0; k < 60; k++) begin
      if ($urandom_range(0, 5) == 0) begin
        do begin
          op = 7'($urandom);
        end while (op == ops[0] || op == ops[1] || op == ops[2] || op == ops[3] || op == ops[4]);
      end else begin
        op = ops[$urandom_range(0, 4)];
      end
      ins = {$urandom} & 32'hFFFF_FF80;
      ins[6:0] = op;
      do_instr(ins, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
               1'($urandom_range(0, 1)), {$urandom} & 32'hFFFF_FFFC,
               1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
